// File: rtl/moteur_colonnes.sv
// moteur_colonnes: falling-brick engine over NB_COL columns of depth HAUTEUR.
// Owns the stack heights, the falling brick, player moves, gravity, line clear
// and game-over detection.
// Build option: define MOTEUR_TOMBER_EN to enable hard drop on bouton_tomber.
module moteur_colonnes #(
  parameter int NB_COL  = 3,
  parameter int HAUTEUR = 7,
  parameter int CW      = $clog2(NB_COL),
  parameter int HW      = $clog2(HAUTEUR + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 bouton_plus,
  input  logic                 bouton_moins,
  input  logic                 bouton_tomber,
  output logic [CW-1:0]        col,
  output logic [HW-1:0]        row,
  output logic [NB_COL*HW-1:0] hauteurs,
  output logic                 aligne,
  output logic                 perdu,
  output logic [15:0]          lignes
);

  typedef enum logic [2:0] {StSpawn, StFall, StLand, StClear, StLost} etat_t;

  localparam int HW1 = HW + 1;
  localparam logic [CW-1:0] ColInit = CW'(NB_COL / 2);
  localparam logic [CW-1:0] ColMax  = CW'(NB_COL - 1);
  localparam logic [HW-1:0] HautMax = HW'(HAUTEUR);
  localparam logic [HW-1:0] RowFond = HW'(HAUTEUR - 1);

  etat_t         etat_q, etat_d;
  logic [CW-1:0] col_q, col_d;
  logic [HW-1:0] row_q, row_d;
  logic [HW-1:0] haut_q [NB_COL];
  logic [HW-1:0] haut_d [NB_COL];
  logic          aligne_q, aligne_d;
  logic          perdu_q, perdu_d;
  logic [15:0]   lignes_q, lignes_d;

  logic          tomber_actif;
  logic          tous_non_vides;
  logic [CW-1:0] col_plus, col_moins;
  logic [HW-1:0] bas_cur;
  logic          plus_ok, moins_ok;

`ifdef MOTEUR_TOMBER_EN
  assign tomber_actif = bouton_tomber;
`else
  logic unused_tomber;
  assign unused_tomber = bouton_tomber;
  assign tomber_actif  = 1'b0;
`endif

  // A brick at row r fits over a stack of height h when r <= HAUTEUR-1-h.
  // Evaluated in HW+1 bits so a full column (h == HAUTEUR) never wraps.
  function automatic logic tient(input logic [HW-1:0] r, input logic [HW-1:0] h);
    return ({1'b0, r} + {1'b0, h}) <= HW1'(HAUTEUR - 1);
  endfunction

  assign col_plus  = col_q + CW'(1);
  assign col_moins = col_q - CW'(1);
  // The current column is never full while falling, so this cannot underflow.
  assign bas_cur   = RowFond - haut_q[col_q];
  assign plus_ok   = (col_q != ColMax) && tient(row_q, haut_q[col_plus]);
  assign moins_ok  = (col_q != '0) && tient(row_q, haut_q[col_moins]);

  // A line exists when every column holds at least one brick.
  always_comb begin
    tous_non_vides = 1'b1;
    for (int i = 0; i < NB_COL; i++) begin
      if (haut_q[i] == '0) tous_non_vides = 1'b0;
    end
  end

  // Next-state logic for the game FSM and all datapath registers.
  always_comb begin
    etat_d   = etat_q;
    col_d    = col_q;
    row_d    = row_q;
    haut_d   = haut_q;
    aligne_d = 1'b0;
    perdu_d  = perdu_q;
    lignes_d = lignes_q;
    unique case (etat_q)
      StSpawn: begin
        col_d = ColInit;
        row_d = '0;
        if (haut_q[ColInit] == HautMax) begin
          etat_d  = StLost;
          perdu_d = 1'b1;
        end else begin
          etat_d = StFall;
        end
      end
      StFall: begin
        if (tomber_actif) begin
          row_d  = bas_cur;
          etat_d = StLand;
        end else if (bouton_plus ^ bouton_moins) begin
          // A single move button owns the cycle; any tick alongside is dropped.
          if (bouton_plus && plus_ok) begin
            col_d = col_plus;
          end else if (bouton_moins && moins_ok) begin
            col_d = col_moins;
          end
        end else if (tick) begin
          if (row_q == bas_cur) begin
            etat_d = StLand;
          end else begin
            row_d = row_q + HW'(1);
          end
        end
      end
      StLand: begin
        haut_d[col_q] = haut_q[col_q] + HW'(1);
        etat_d        = StClear;
      end
      StClear: begin
        if (tous_non_vides) begin
          for (int i = 0; i < NB_COL; i++) begin
            haut_d[i] = haut_q[i] - HW'(1);
          end
          aligne_d = 1'b1;
          lignes_d = lignes_q + 16'd1;
        end
        etat_d = StSpawn;
      end
      StLost: begin
        // Frozen until reset.
      end
      default: etat_d = StSpawn;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      etat_q   <= StSpawn;
      col_q    <= ColInit;
      row_q    <= '0;
      for (int i = 0; i < NB_COL; i++) haut_q[i] <= '0;
      aligne_q <= 1'b0;
      perdu_q  <= 1'b0;
      lignes_q <= '0;
    end else begin
      etat_q   <= etat_d;
      col_q    <= col_d;
      row_q    <= row_d;
      haut_q   <= haut_d;
      aligne_q <= aligne_d;
      perdu_q  <= perdu_d;
      lignes_q <= lignes_d;
    end
  end

  // Pack registered heights for the display and score blocks.
  always_comb begin
    hauteurs = '0;
    for (int i = 0; i < NB_COL; i++) begin
      hauteurs[i*HW +: HW] = haut_q[i];
    end
  end

  assign col    = col_q;
  assign row    = row_q;
  assign aligne = aligne_q;
  assign perdu  = perdu_q;
  assign lignes = lignes_q;

endmodule

// File: tb/tb_moteur_colonnes.sv
// Bench for moteur_colonnes (3 columns, depth 7). Expectations are queued
// before each clock edge and checked against the outputs after it.
module tb_moteur_colonnes;

  localparam int NB_COL  = 3;
  localparam int HAUTEUR = 7;
  localparam int CW      = 2;
  localparam int HW      = 3;
  localparam int ColInit = NB_COL / 2;

  localparam int SelCol = 0, SelRow = 1, SelHaut = 2, SelAligne = 3, SelPerdu = 4,
                 SelLignes = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, bouton_plus = 1'b0, bouton_moins = 1'b0, bouton_tomber = 1'b0;
  logic [CW-1:0]        col;
  logic [HW-1:0]        row;
  logic [NB_COL*HW-1:0] hauteurs;
  logic                 aligne, perdu;
  logic [15:0]          lignes;

  moteur_colonnes #(.NB_COL(NB_COL), .HAUTEUR(HAUTEUR)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .bouton_plus  (bouton_plus),
    .bouton_moins (bouton_moins),
    .bouton_tomber(bouton_tomber),
    .col          (col),
    .row          (row),
    .hauteurs     (hauteurs),
    .aligne       (aligne),
    .perdu        (perdu),
    .lignes       (lignes)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } attente_t;

  attente_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int hm[NB_COL];
  int lignes_m = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelCol:    return 32'(col);
      SelRow:    return 32'(row);
      SelHaut:   return 32'(hauteurs);
      SelAligne: return 32'(aligne);
      SelPerdu:  return 32'(perdu);
      SelLignes: return 32'(lignes);
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] pack_h();
    logic [31:0] r = '0;
    for (int i = 0; i < NB_COL; i++) r |= 32'(hm[i]) << (i * HW);
    return r;
  endfunction

  task automatic attendre(input string tag, input int sel, input int val);
    attente_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    sb_q.push_back(e);
  endtask

  task automatic verifier();
    attente_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic attendre_reset(input string tag);
    attendre({tag, "_col"}, SelCol, ColInit);
    attendre({tag, "_row"}, SelRow, 0);
    attendre({tag, "_haut"}, SelHaut, 0);
    attendre({tag, "_aligne"}, SelAligne, 0);
    attendre({tag, "_perdu"}, SelPerdu, 0);
    attendre({tag, "_lignes"}, SelLignes, 0);
  endtask

  // One clock with the given pulses, then check everything queued for it.
  task automatic cycle(input logic t, input logic p, input logic m, input logic d);
    tick = t;
    bouton_plus = p;
    bouton_moins = m;
    bouton_tomber = d;
    @(posedge clk);
    #1;
    tick = 1'b0;
    bouton_plus = 1'b0;
    bouton_moins = 1'b0;
    bouton_tomber = 1'b0;
    verifier();
  endtask

  // The three edges after the landing edge: LAND, CLEAR, SPAWN.
  task automatic finir_atterrissage(input int c);
    bit tous;
    hm[c]++;
    attendre("land_haut", SelHaut, int'(pack_h()));
    attendre("land_aligne", SelAligne, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    tous = 1'b1;
    for (int i = 0; i < NB_COL; i++) if (hm[i] == 0) tous = 1'b0;
    if (tous) begin
      for (int i = 0; i < NB_COL; i++) hm[i]--;
      lignes_m++;
    end
    attendre("clear_haut", SelHaut, int'(pack_h()));
    attendre("clear_aligne", SelAligne, int'(tous));
    attendre("clear_lignes", SelLignes, lignes_m);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    attendre("spawn_col", SelCol, ColInit);
    attendre("spawn_row", SelRow, 0);
    attendre("spawn_aligne", SelAligne, 0);
    attendre("spawn_perdu", SelPerdu, int'(hm[ColInit] == HAUTEUR));
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // From a fresh brick: walk to column c, then tick it down until it lands.
  task automatic drop_to(input int c);
    if (c < ColInit) repeat (ColInit - c) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    else repeat (c - ColInit) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    attendre("drop_col", SelCol, c);
    repeat (HAUTEUR - hm[c]) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    finir_atterrissage(c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NB_COL; i++) hm[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    attendre_reset("reset");
    verifier();
    reset = 1'b1;

    // SPAWN cycle: a tick here is discarded.
    attendre("spawn_tick_ign", SelRow, 0);
    attendre("spawn_col0", SelCol, ColInit);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Gravity down the centre column.
    for (int i = 1; i < HAUTEUR; i++) begin
      attendre("tick_row", SelRow, i);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    attendre("land_edge_row", SelRow, HAUTEUR - 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    attendre("land_btn_ign", SelCol, ColInit);
    finir_atterrissage(ColInit);

    // Moves, edges and simultaneous buttons.
    attendre("moins_ok", SelCol, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    attendre("moins_nowrap", SelCol, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    attendre("both_btn_col", SelCol, 0);
    attendre("both_btn_row", SelRow, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    attendre("both_tick_col", SelCol, 0);
    attendre("both_tick_row", SelRow, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    attendre("move_tick_col", SelCol, 1);
    attendre("move_tick_row", SelRow, 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    attendre("plus_ok", SelCol, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    attendre("plus_nowrap", SelCol, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (HAUTEUR - 1) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    finir_atterrissage(2);

    // Completing the bottom row clears it.
    drop_to(0);

    // Tall column 2 blocks a lateral move below its top.
    repeat (HAUTEUR - 1) drop_to(2);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    attendre("rej_row_col", SelCol, ColInit);
    attendre("rej_row_row", SelRow, 3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (HAUTEUR - hm[ColInit] - 3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    finir_atterrissage(ColInit);
    attendre("acc_row0", SelCol, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    finir_atterrissage(2);
    attendre("rej_full", SelCol, ColInit);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Fill the spawn column: game over.
    while (hm[ColInit] < HAUTEUR) drop_to(ColInit);
    for (int i = 0; i < 3; i++) begin
      attendre("lost_col", SelCol, ColInit);
      attendre("lost_row", SelRow, 0);
      attendre("lost_haut", SelHaut, int'(pack_h()));
      attendre("lost_perdu", SelPerdu, 1);
      attendre("lost_aligne", SelAligne, 0);
      attendre("lost_lignes", SelLignes, lignes_m);
      cycle(1'b1, (i == 0), (i == 1), 1'b1);
    end

    // Asynchronous reset out of LOST.
    #2 reset = 1'b0;
    #1;
    attendre_reset("reset_lost");
    verifier();
    for (int i = 0; i < NB_COL; i++) hm[i] = 0;
    lignes_m = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    attendre("respawn_row", SelRow, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MOTEUR_TOMBER_EN
    attendre("tomber_row", SelRow, HAUTEUR - 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    finir_atterrissage(ColInit);
`else
    attendre("tomber_ign_row", SelRow, 0);
    attendre("tomber_ign_haut", SelHaut, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    attendre("tick_after_row", SelRow, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-fall.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    attendre_reset("reset_fall");
    verifier();
    @(posedge clk);
    #1 reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
